// File: rtl/vga_pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pll_seq_pkg
//  Purpose  : Shared state encoding, default timing constants and a
//             counter-width helper for the VGA PLL power-up sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pll_seq_pkg;

   // Sequencer state encoding (3 bits)
   localparam logic [2:0] HOLD   = 3'd0;
   localparam logic [2:0] WAIT   = 3'd1;
   localparam logic [2:0] STABLE = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] FAULT  = 3'd4;

   typedef enum logic [2:0] {
      ST_HOLD   = HOLD,
      ST_WAIT   = WAIT,
      ST_STABLE = STABLE,
      ST_RUN    = RUN,
      ST_FAULT  = FAULT
   } state_e;

   // Default timing for a 48 MHz board clock
   localparam int c_def_rst_cycles    = 16;
   localparam int c_def_lock_timeout  = 4800;
   localparam int c_def_stable_cycles = 1024;
   localparam int c_def_max_retries   = 3;

   // Width of a counter that must hold 0 .. n-1 (never below 1 bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : vga_pll_seq_pkg
`default_nettype wire

// File: rtl/vga_pll_seq_lock_filter.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_filter
//  Purpose  : Two-flop synchronizer for the asynchronous PLL lock output and
//             a consecutive-high counter. stableDone is high in the cycle in
//             which the STABLE_CYCLES-th consecutive synced-high sample is seen.
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_filter
   import vga_pll_seq_pkg::*;
#(
   parameter int STABLE_CYCLES = c_def_stable_cycles
) (
   input  logic clkin,
   input  logic reset_n,
   input  logic clr,
   input  logic pllLocked,
   output logic lockS,
   output logic stableDone
);

   localparam int             CW     = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  c_last = CW'(STABLE_CYCLES - 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;

   // Bring pllLocked into the clkin domain
   always_ff @(posedge clkin) begin
      if (!reset_n) r_sync <= 2'b00;
      else          r_sync <= {r_sync[0], pllLocked};
   end

   assign lockS = r_sync[1];

   // Count prior consecutive synced-high cycles, holding at the terminal value
   always_ff @(posedge clkin) begin
      if (!reset_n || clr || !lockS) r_cnt <= '0;
      else if (r_cnt != c_last)      r_cnt <= r_cnt + 1'b1;
   end

   assign stableDone = lockS && (r_cnt == c_last);

endmodule : pll_lock_filter
`default_nettype wire

// File: rtl/vga_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pll_sequencer
//  Purpose  : Power-up / relock sequencer for the VGA pixel-clock PLL.
//             Drives PLL reset, qualifies lock, gates vgaReady, detects lock
//             timeout and loss of lock, retries and reports a sticky fault.
//  Config   : VGA_PLL_SEQ_AUTORETRY_EN - when defined, failures retry up to
//             MAX_RETRIES times; otherwise every failure goes to FAULT.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pll_sequencer
   import vga_pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = c_def_rst_cycles,
   parameter int LOCK_TIMEOUT  = c_def_lock_timeout,
   parameter int STABLE_CYCLES = c_def_stable_cycles,
   parameter int MAX_RETRIES   = c_def_max_retries
) (
   input  logic                               clkin,
   input  logic                               reset_n,
   input  logic                               pllLocked,
   input  logic                               restart,
   output logic                               pllReset,
   output logic                               vgaReady,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retryCnt
);

   localparam int             RW          = $clog2(MAX_RETRIES + 1);
   localparam int             HW          = cnt_width(RST_CYCLES);
   localparam int             TW          = cnt_width(LOCK_TIMEOUT);
   localparam logic [HW-1:0]  c_hold_last = HW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]  c_tout_last = TW'(LOCK_TIMEOUT - 1);
`ifdef VGA_PLL_SEQ_AUTORETRY_EN
   localparam logic [RW-1:0]  c_retry_max = RW'(MAX_RETRIES);
`endif

   state_e        r_state;
   state_e        w_state_nxt;
   logic [HW-1:0] r_hcnt;
   logic [TW-1:0] r_tcnt;
   logic [RW-1:0] r_retry;
   logic [RW-1:0] w_retry_nxt;
   logic          r_pll_reset;
   logic          r_vga_ready;
   logic          r_fault;
   logic          w_lock_s;
   logic          w_stable_done;
   logic          w_filter_clr;
   logic          w_hold_done;
   logic          w_timeout;
   logic          w_fail;
   logic          w_locking;

   // While the PLL is held in reset its lock output means nothing
   assign w_filter_clr = (r_state == ST_HOLD) || (r_state == ST_FAULT);
   assign w_locking    = (r_state == ST_WAIT) || (r_state == ST_STABLE);
   assign w_hold_done  = (r_hcnt == c_hold_last);
   assign w_timeout    = w_locking && (r_tcnt == c_tout_last);

   pll_lock_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_lock_filter (
      .clkin      (clkin),
      .reset_n    (reset_n),
      .clr        (w_filter_clr),
      .pllLocked  (pllLocked),
      .lockS      (w_lock_s),
      .stableDone (w_stable_done)
   );

   // Next state and retry count; restart overrides any same-cycle failure
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_fail      = 1'b0;
      case (r_state)
         ST_HOLD: begin
            if (w_hold_done) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_timeout)          w_fail      = 1'b1;
            else if (w_stable_done) w_state_nxt = ST_RUN;
            else if (w_lock_s)      w_state_nxt = ST_STABLE;
         end
         ST_STABLE: begin
            if (w_timeout)          w_fail      = 1'b1;
            else if (!w_lock_s)     w_state_nxt = ST_WAIT;
            else if (w_stable_done) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!w_lock_s) w_fail = 1'b1;
         end
         ST_FAULT: begin
            w_state_nxt = ST_FAULT;
         end
         default: begin
            w_state_nxt = ST_HOLD;
         end
      endcase
      if (w_fail) begin
`ifdef VGA_PLL_SEQ_AUTORETRY_EN
         if (r_retry != c_retry_max) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_HOLD;
         end else begin
            w_state_nxt = ST_FAULT;
         end
`else
         w_state_nxt = ST_FAULT;
`endif
      end
      if (restart) begin
         w_state_nxt = ST_HOLD;
         w_retry_nxt = '0;
      end
   end

   // State register and registered outputs; ready drops on the edge leaving RUN
   always_ff @(posedge clkin) begin
      if (!reset_n) begin
         r_state     <= ST_HOLD;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_vga_ready <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_retry     <= w_retry_nxt;
         r_pll_reset <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_FAULT);
         r_vga_ready <= (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
         r_fault     <= (w_state_nxt == ST_FAULT);
      end
   end

   // Hold counter: times the PLL reset pulse of each attempt
   always_ff @(posedge clkin) begin
      if (!reset_n || restart || (r_state != ST_HOLD) || w_hold_done) r_hcnt <= '0;
      else                                                             r_hcnt <= r_hcnt + 1'b1;
   end

   // Timeout counter: runs through WAIT and STABLE, survives STABLE->WAIT
   always_ff @(posedge clkin) begin
      if (!reset_n || restart || !w_locking || w_timeout) r_tcnt <= '0;
      else                                                r_tcnt <= r_tcnt + 1'b1;
   end

   assign pllReset = r_pll_reset;
   assign vgaReady = r_vga_ready;
   assign fault    = r_fault;
   assign retryCnt = r_retry;

endmodule : vga_pll_sequencer
`default_nettype wire

// File: tb/tb_vga_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pll_sequencer
//  Purpose  : Self-checking bench for vga_pll_sequencer: directed scenarios
//             with literal expectations plus randomized lock/restart/reset
//             traffic checked every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pll_sequencer;

   localparam int RST = 4;
   localparam int TO  = 40;
   localparam int ST  = 8;
   localparam int MAX = 2;
`ifdef VGA_PLL_SEQ_AUTORETRY_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       pllLocked;
   logic       restart;
   logic       pllReset;
   logic       vgaReady;
   logic       fault;
   logic [1:0] retryCnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_pll_sequencer #(
      .RST_CYCLES    (RST),
      .LOCK_TIMEOUT  (TO),
      .STABLE_CYCLES (ST),
      .MAX_RETRIES   (MAX)
   ) dut (
      .clkin     (clk),
      .reset_n   (reset_n),
      .pllLocked (pllLocked),
      .restart   (restart),
      .pllReset  (pllReset),
      .vgaReady  (vgaReady),
      .fault     (fault),
      .retryCnt  (retryCnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_valid = 0;
   int m_ph, m_nph, m_held, m_waited, m_streak, m_retry;
   bit m_s1, m_s2, m_ls, m_fail;
   bit e_prst, e_rdy, e_flt;

   // One model step per clock edge: phase bookkeeping from elapsed-cycle counts
   always @(posedge clk) begin
      m_ls = m_s2;
      if (!reset_n) begin
         m_ph = P_HOLD; m_held = 0; m_waited = 0; m_streak = 0; m_retry = 0;
         m_s1 = 0; m_s2 = 0; e_prst = 1; e_rdy = 0; e_flt = 0; m_valid = 1;
      end else if (m_valid) begin
         m_streak = (m_ph == P_HOLD || m_ph == P_FAULT) ? 0 : (m_ls ? m_streak + 1 : 0);
         m_nph = m_ph; m_fail = 0;
         case (m_ph)
            P_HOLD: begin
               m_held++;
               if (m_held == RST) m_nph = P_WAIT;
            end
            P_WAIT, P_STAB: begin
               m_waited++;
               if (m_waited == TO)     m_fail = 1;
               else if (m_streak >= ST) m_nph = P_RUN;
               else                    m_nph = m_ls ? P_STAB : P_WAIT;
            end
            P_RUN: if (!m_ls) m_fail = 1;
            default: ;
         endcase
         if (m_fail) begin
            if (AUTO && m_retry < MAX) begin m_retry++; m_nph = P_HOLD; end
            else m_nph = P_FAULT;
         end
         if (restart) begin m_nph = P_HOLD; m_retry = 0; end
         e_rdy = (m_ph == P_RUN) && (m_nph == P_RUN);
         if (m_nph != P_HOLD || restart) m_held = 0;
         if (!(m_nph == P_WAIT || m_nph == P_STAB) || restart) m_waited = 0;
         m_ph   = m_nph;
         e_prst = (m_nph == P_HOLD) || (m_nph == P_FAULT);
         e_flt  = (m_nph == P_FAULT);
         m_s2 = m_s1; m_s1 = pllLocked;
      end
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("mdl_pllReset", {31'b0, pllReset}, {31'b0, e_prst});
         chk("mdl_vgaReady", {31'b0, vgaReady}, {31'b0, e_rdy});
         chk("mdl_fault",    {31'b0, fault},    {31'b0, e_flt});
         chk("mdl_retryCnt", {30'b0, retryCnt}, m_retry);
      end
   end

   task automatic wait_prst(input logic lvl, input string nm);
      int n = 0;
      while (pllReset !== lvl && n < 300) begin @(negedge clk); n++; end
      if (pllReset !== lvl) chk(nm, {31'b0, pllReset}, {31'b0, lvl});
   endtask

   task automatic pulse_restart();
      restart = 1'b1; @(negedge clk); restart = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k, hc, w, rate;
      reset_n = 1'b0; pllLocked = 1'b0; restart = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pllReset", {31'b0, pllReset}, 32'd1);
      chk("rst_vgaReady", {31'b0, vgaReady}, 32'd0);
      chk("rst_fault",    {31'b0, fault},    32'd0);
      chk("rst_retryCnt", {30'b0, retryCnt}, 32'd0);

      // 1. nominal power-up
      reset_n = 1'b1;
      hc = 0;
      while (pllReset && hc < 100) begin hc++; @(negedge clk); end
      chk("t1_prst_cycles", hc, 32'd4);
      repeat (10) @(negedge clk);
      pllLocked = 1'b1;
      k = 0;
      while (!vgaReady && k < 100) begin @(negedge clk); k++; end
      chk("t1_ready_latency", k, 32'd11);

      // 2. glitchy lock
      pllLocked = 1'b0; do_reset();
      wait_prst(1'b0, "t2_prst_fall");
      repeat (10) @(negedge clk);
      pllLocked = 1'b1; repeat (5) @(negedge clk);
      pllLocked = 1'b0; @(negedge clk);
      pllLocked = 1'b1;
      k = 0;
      while (!vgaReady && k < 100) begin @(negedge clk); k++; end
      chk("t2_ready_latency", k, 32'd11);
      chk("t2_retryCnt", {30'b0, retryCnt}, 32'd0);

      // 4. loss of lock in RUN
      pllLocked = 1'b0;
      k = 0;
      while (vgaReady && k < 20) begin @(negedge clk); k++; end
      chk("t4_ready_fall", k, 32'd3);
      chk("t4_retryCnt", {30'b0, retryCnt}, AUTO ? 32'd1 : 32'd0);
      chk("t4_pllReset", {31'b0, pllReset}, 32'd1);
      chk("t4_fault",    {31'b0, fault},    AUTO ? 32'd0 : 32'd1);

      // 6. mid-sequence reset while in STABLE
      if (!AUTO) pulse_restart();
      wait_prst(1'b0, "t6_prst_fall");
      pllLocked = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b0; pllLocked = 1'b0;
      @(negedge clk);
      chk("t6_pllReset", {31'b0, pllReset}, 32'd1);
      chk("t6_vgaReady", {31'b0, vgaReady}, 32'd0);
      chk("t6_fault",    {31'b0, fault},    32'd0);
      chk("t6_retryCnt", {30'b0, retryCnt}, 32'd0);
      reset_n = 1'b1;

      // 3. timeout with lock held low
      wait_prst(1'b0, "t3_prst_fall");
      w = 0;
      while (!pllReset && w < 100) begin w++; @(negedge clk); end
      chk("t3_wait_cycles", w, 32'd40);
      chk("t3_retry_first", {30'b0, retryCnt}, AUTO ? 32'd1 : 32'd0);
      chk("t3_fault_first", {31'b0, fault},    AUTO ? 32'd0 : 32'd1);
      k = 0;
      while (!fault && k < 500) begin @(negedge clk); k++; end
      chk("t3_fault",    {31'b0, fault},    32'd1);
      chk("t3_retryCnt", {30'b0, retryCnt}, AUTO ? 32'd2 : 32'd0);
      chk("t3_pllReset", {31'b0, pllReset}, 32'd1);

      // 5a. restart from FAULT
      pulse_restart();
      chk("t5a_fault",    {31'b0, fault},    32'd0);
      chk("t5a_retryCnt", {30'b0, retryCnt}, 32'd0);
      chk("t5a_pllReset", {31'b0, pllReset}, 32'd1);

      // 5b. restart in the same cycle as a timeout
      wait_prst(1'b0, "t5b_prst_fall");
      repeat (39) @(negedge clk);
      pulse_restart();
      chk("t5b_fault",    {31'b0, fault},    32'd0);
      chk("t5b_retryCnt", {30'b0, retryCnt}, 32'd0);
      chk("t5b_pllReset", {31'b0, pllReset}, 32'd1);

      // Randomized lock / restart / reset traffic, model-checked each cycle
      for (int blk = 0; blk < 8; blk++) begin
         rate = $urandom_range(4, 60);
         for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, rate - 1) == 0) pllLocked = ~pllLocked;
            restart = ($urandom_range(0, 199) == 0);
            reset_n = ($urandom_range(0, 399) != 0);
         end
      end
      @(negedge clk);
      restart = 1'b0; reset_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule : tb_vga_pll_sequencer
`default_nettype wire
